// File: rtl/ha_operand_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : ha_operand_serializer
//  Description : Captures two WIDTH-bit operands on a valid/ready load
//                handshake and streams them LSB-first, one bit pair per
//                accepted beat, toward a registered half adder. out_last
//                frames the MSB beat so the collector can rebuild words.
//  Revision    : 1.0 - initial release
// ============================================================================
module ha_operand_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_a,
   output logic             out_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   // Counter must hold values 0..WIDTH-1; one spare code keeps WIDTH=1 legal.
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sh_a_q, sh_a_d;
   logic [WIDTH-1:0]   sh_b_q, sh_b_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               busy_w;
   logic               last_w;
   logic               accept_w;
   logic               load_w;

   assign busy_w   = (state_q == S_SHIFT);
   assign last_w   = busy_w && (cnt_q == CNT_W'(WIDTH - 1));
   assign accept_w = busy_w && out_ready;
   // Accepting the final beat frees the registers in the same edge, which
   // lets the next word load with no idle bubble between words.
   assign load_ready = !busy_w || (last_w && out_ready);
   assign load_w     = load_valid && load_ready;

   assign busy      = busy_w;
   assign out_valid = busy_w;
   assign out_last  = last_w;
   assign out_a     = sh_a_q[0];
   assign out_b     = sh_b_q[0];

   // Next-state: load has priority, then beat advance or end-of-word clear.
   always_comb begin
      state_d = state_q;
      sh_a_d  = sh_a_q;
      sh_b_d  = sh_b_q;
      cnt_d   = cnt_q;
      if (load_w) begin
         state_d = S_SHIFT;
         sh_a_d  = op_a;
         sh_b_d  = op_b;
         cnt_d   = '0;
      end else if (accept_w) begin
         if (last_w) begin
            state_d = S_IDLE;
            sh_a_d  = '0;
            sh_b_d  = '0;
            cnt_d   = '0;
         end else begin
            sh_a_d  = sh_a_q >> 1;
            sh_b_d  = sh_b_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= S_IDLE;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ha_operand_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ha_operand_serializer
//  Description : Directed self-checking bench for ha_operand_serializer,
//                WIDTH=8 and WIDTH=1 builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ha_operand_serializer;

   logic       CLK = 1'b0;
   logic       reset;

   // WIDTH=8 instance signals
   logic       lv8, lr8, oa8, ob8, ov8, ordy8, ol8, bz8;
   logic [7:0] opa8, opb8;

   // WIDTH=1 instance signals
   logic       lv1, lr1, oa1, ob1, ov1, ordy1, ol1, bz1;
   logic [0:0] opa1, opb1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   ha_operand_serializer #(.WIDTH(8)) u_dut8 (
      .CLK        (CLK),
      .reset      (reset),
      .load_valid (lv8),
      .load_ready (lr8),
      .op_a       (opa8),
      .op_b       (opb8),
      .out_a      (oa8),
      .out_b      (ob8),
      .out_valid  (ov8),
      .out_ready  (ordy8),
      .out_last   (ol8),
      .busy       (bz8)
   );

   ha_operand_serializer #(.WIDTH(1)) u_dut1 (
      .CLK        (CLK),
      .reset      (reset),
      .load_valid (lv1),
      .load_ready (lr1),
      .op_a       (opa1),
      .op_b       (opb1),
      .out_a      (oa1),
      .out_b      (ob1),
      .out_valid  (ov1),
      .out_ready  (ordy1),
      .out_last   (ol1),
      .busy       (bz1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [7:0] ea, eb;
      int         k, cyc;
      logic       rdy;

      reset = 1'b1; lv8 = 1'b1; opa8 = 8'hA5; opb8 = 8'h3C; ordy8 = 1'b1;
      lv1 = 1'b0; opa1 = 1'b0; opb1 = 1'b0; ordy1 = 1'b1;
      #1;

      // ---------------- Reset with load_valid asserted ----------------
      step(); step();
      chk("rst_valid", {31'd0, ov8}, 32'd0);
      chk("rst_busy",  {31'd0, bz8}, 32'd0);
      chk("rst_last",  {31'd0, ol8}, 32'd0);
      chk("rst_outa",  {31'd0, oa8}, 32'd0);
      chk("rst_outb",  {31'd0, ob8}, 32'd0);
      chk("rst_lready",{31'd0, lr8}, 32'd1);
      reset = 1'b0; lv8 = 1'b0;
      step();
      chk("rst_nocap_valid", {31'd0, ov8}, 32'd0);
      chk("rst_nocap_lready",{31'd0, lr8}, 32'd1);

      // ---------------- Basic word A5/3C, out_ready high ----------------
      ea = 8'b1010_0101;   // A5
      eb = 8'b0011_1100;   // 3C
      opa8 = 8'hA5; opb8 = 8'h3C; lv8 = 1'b1; ordy8 = 1'b1;
      step();
      lv8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("basic_valid", {31'd0, ov8}, 32'd1);
         chk("basic_a",     {31'd0, oa8}, {31'd0, ea[i]});
         chk("basic_b",     {31'd0, ob8}, {31'd0, eb[i]});
         chk("basic_last",  {31'd0, ol8}, (i == 7) ? 32'd1 : 32'd0);
         step();
      end
      chk("basic_end_valid", {31'd0, ov8}, 32'd0);
      chk("basic_end_busy",  {31'd0, bz8}, 32'd0);
      chk("basic_end_lready",{31'd0, lr8}, 32'd1);

      // ---------------- Stall with out_ready pattern 1,0,0 ----------------
      lv8 = 1'b1;
      step();
      lv8 = 1'b0;
      k = 0; cyc = 0;
      while (k < 8 && cyc < 100) begin
         rdy   = ((cyc % 3) == 0);
         ordy8 = rdy;
         chk("stall_valid", {31'd0, ov8}, 32'd1);
         chk("stall_a",     {31'd0, oa8}, {31'd0, ea[k[2:0]]});
         chk("stall_b",     {31'd0, ob8}, {31'd0, eb[k[2:0]]});
         chk("stall_last",  {31'd0, ol8}, (k == 7) ? 32'd1 : 32'd0);
         if (rdy) k++;
         step();
         cyc++;
      end
      chk("stall_beats", k, 32'd8);
      chk("stall_end_valid", {31'd0, ov8}, 32'd0);
      ordy8 = 1'b1;

      // ---------------- Back-to-back: A5/3C then FF/01 ----------------
      lv8 = 1'b1; opa8 = 8'hA5; opb8 = 8'h3C;
      step();
      lv8 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("b2b_w1_a", {31'd0, oa8}, {31'd0, ea[i]});
         step();
      end
      opa8 = 8'hFF; opb8 = 8'h01; lv8 = 1'b1;
      chk("b2b_w1_last",   {31'd0, ol8}, 32'd1);
      chk("b2b_w1_lready", {31'd0, lr8}, 32'd1);
      step();
      lv8 = 1'b0;
      ea = 8'hFF; eb = 8'h01;
      for (int i = 0; i < 8; i++) begin
         chk("b2b_w2_valid", {31'd0, ov8}, 32'd1);
         chk("b2b_w2_a",     {31'd0, oa8}, {31'd0, ea[i]});
         chk("b2b_w2_b",     {31'd0, ob8}, {31'd0, eb[i]});
         chk("b2b_w2_last",  {31'd0, ol8}, (i == 7) ? 32'd1 : 32'd0);
         step();
      end
      chk("b2b_end_valid", {31'd0, ov8}, 32'd0);

      // ---------------- Mid-word reset after beat 3 ----------------
      ea = 8'hA5;
      lv8 = 1'b1; opa8 = 8'hA5; opb8 = 8'h3C;
      step();
      lv8 = 1'b0;
      step(); step(); step();
      chk("mid_pre_valid", {31'd0, ov8}, 32'd1);
      chk("mid_pre_a",     {31'd0, oa8}, {31'd0, ea[3]});
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_valid", {31'd0, ov8}, 32'd0);
      chk("mid_rst_busy",  {31'd0, bz8}, 32'd0);
      chk("mid_rst_lready",{31'd0, lr8}, 32'd1);
      chk("mid_rst_a",     {31'd0, oa8}, 32'd0);
      step(); step();
      chk("mid_after_valid", {31'd0, ov8}, 32'd0);

      // ---------------- WIDTH=1 build ----------------
      lv1 = 1'b1; opa1 = 1'b1; opb1 = 1'b1; ordy1 = 1'b1;
      step();
      lv1 = 1'b0;
      chk("w1_valid", {31'd0, ov1}, 32'd1);
      chk("w1_a",     {31'd0, oa1}, 32'd1);
      chk("w1_b",     {31'd0, ob1}, 32'd1);
      chk("w1_last",  {31'd0, ol1}, 32'd1);
      step();
      chk("w1_end_valid", {31'd0, ov1}, 32'd0);
      chk("w1_end_busy",  {31'd0, bz1}, 32'd0);
      chk("w1_end_lready",{31'd0, lr1}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ha_operand_serializer.md
Name: ha_operand_serializer

Overview:
Upstream feeder for the registered half adder. Accepts two WIDTH-bit operands through a valid/ready load handshake. Presents them LSB-first as one bit pair per accepted beat on out_a/out_b, which drive the adder's in1/in2. Beat flow control uses out_valid/out_ready, and out_last marks the MSB beat so a downstream collector can frame sum/cout words.

Parameters:
WIDTH, 8, operand width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
CLK  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
load_valid  input  1  op_a/op_b are valid this cycle.
load_ready  output  1  block can capture operands this cycle.
op_a  input  WIDTH  operand A, captured on load handshake.
op_b  input  WIDTH  operand B, captured on load handshake.
out_a  output  1  current bit of A (to half adder in1).
out_b  output  1  current bit of B (to half adder in2).
out_valid  output  1  out_a/out_b/out_last hold a valid beat.
out_ready  input  1  consumer accepts the beat this cycle.
out_last  output  1  current beat is bit WIDTH-1.
busy  output  1  a word is being shifted out.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high; name is reset. Reset overrides every other input in the same edge.
- After reset:
  - State is IDLE.
  - Shift registers sh_a/sh_b = 0, out_a = out_b = 0.
  - Bit counter = 0.
  - out_valid = 0, out_last = 0, busy = 0, load_ready = 1.
- States: IDLE and SHIFT. busy = (state == SHIFT). out_valid = busy.
- load_ready = IDLE, or (SHIFT and out_last and out_ready). This allows back-to-back words with no bubble.
- Load handshake: when load_valid && load_ready at a rising edge:
  - sh_a <= op_a, sh_b <= op_b, count <= 0, state <= SHIFT.
  - First beat (bit 0) appears in the cycle after the handshake. Load-to-first-beat latency is 1 cycle.
- load_valid while load_ready = 0 is ignored. Operands are not captured, and no error is flagged.
- Beat outputs are taken directly from registers: out_a = sh_a[0], out_b = sh_b[0].
- out_last = SHIFT and (count == WIDTH-1).
- Beat accept (out_valid && out_ready) when not last:
  - sh_a, sh_b shift right by 1, zero-filled.
  - count <= count+1.
- Beat accept when last:
  - If load_valid is high the same cycle, load new operands and stay in SHIFT.
  - Otherwise go to IDLE, clear sh_a/sh_b, count <= 0.
- Stall: out_valid high with out_ready low. out_a, out_b, out_last, count and state hold unchanged for any number of cycles.
- Throughput is one bit per cycle with out_ready held high, so a word takes exactly WIDTH beats.
- WIDTH = 1: the first beat is also last, so out_last = 1 on every beat.
- Reset mid-word: the in-flight word is discarded. No further beats are produced; outputs take reset values on the next edge.
- out_valid never drops without an accepted last beat, except via reset.
- The block does not inspect the adder outputs.

Test Plan:
- Reset check: assert reset 2 cycles with load_valid = 1 -> all outputs at reset values, load_ready = 1 after release, no operand captured.
- Basic word: WIDTH = 8, op_a = 8'hA5, op_b = 8'h3C, out_ready held 1.
  - Beats start 1 cycle after load.
  - out_a sequence 1,0,1,0,0,1,0,1 and out_b sequence 0,0,1,1,1,1,0,0.
  - out_last only on beat 8; then out_valid = 0, busy = 0.
- Stall: same operands, out_ready toggled 1,0,0,1,...
  - Bits never skipped or duplicated.
  - Outputs stable during every low cycle.
  - 8 accepted beats total.
- Back-to-back: second load (op_a = 8'hFF, op_b = 8'h01) presented with load_valid held high.
  - Captured on the last beat of word 1.
  - Word 2 bit 0 (out_a = 1, out_b = 1) appears the next cycle with no idle gap.
- Mid-word reset: reset asserted after beat 3 of 8'hA5 -> out_valid = 0 the next cycle, no further beats, load_ready = 1.
- WIDTH = 1 build: op_a = 1, op_b = 1 -> single beat with out_a = 1, out_b = 1, out_last = 1, then IDLE.
